tmp_seq_ctrl: RTL and testbench



---
 rtl/tmp_seq_pkg.sv | 44 ++++
 rtl/tmp_seq_ctrl_if.sv | 27 ++
 rtl/tmp_seq_rr.sv | 39 +++
 rtl/tmp_seq_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_tmp_seq_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/tmp_seq_pkg.sv
// rtl/tmp_seq_pkg.sv - shared types, default timing constants and helpers for the temperature sequencer
//
// Purpose : common definitions imported by tmp_seq_ctrl, tmp_seq_rr and tmp_seq_ctrl_if.
// Contents: state_e  - sequencer phase encoding
//           sw_t     - packed bundle of the analog switch / precharge controls
//           DEF_*    - default parameter values
//           idx_w()  - index width for an N-entry set, never below 1 bit
package tmp_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRECHARGE = 3'd1,
    ST_BLANK     = 3'd2,
    ST_SMALL     = 3'd3,
    ST_BIG       = 3'd4,
    ST_OUTPUT    = 3'd5
  } state_e;

  typedef struct packed {
    logic pi1;
    logic pi2;
    logic pii1;
    logic pii2;
    logic pa;
    logic pb;
    logic pc;
    logic pd;
    logic pre_chrg;
  } sw_t;

  localparam int DEF_N_CH       = 4;
  localparam int DEF_CNT_W      = 8;
  localparam int DEF_PRECHG_CYC = 11;
  localparam int DEF_BLANK_CYC  = 1;
  localparam int DEF_DIODE_CYC  = 2;
  localparam int DEF_CONV_CYC   = 128;
  localparam int DEF_SETUP_CYC  = 6;

  // $clog2(1) is 0, which would give zero-width index buses for a single channel.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tmp_seq_ctrl_if.sv
// rtl/tmp_seq_ctrl_if.sv - result handshake interface between the sequencer and the readout logic
//
// Purpose : carries one conversion result with a valid/ready handshake.
// Signals : result    [CNT_W] - count of comparator ones
//           result_ch [IDX_W] - channel index the result belongs to
//           valid             - result available (producer)
//           ready             - consumer accepts the result
// Modports: master - sequencer side (drives result/result_ch/valid)
//           slave  - readout side (drives ready)
interface tmp_seq_ctrl_if
  import tmp_seq_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int CNT_W = DEF_CNT_W
) ();

  localparam int IDX_W = idx_w(N_CH);

  logic [CNT_W-1:0] result;
  logic [IDX_W-1:0] result_ch;
  logic             valid;
  logic             ready;

  modport master (output result, output result_ch, output valid, input ready);
  modport slave  (input result, input result_ch, input valid, output ready);

endinterface

// File: rtl/tmp_seq_rr.sv
// rtl/tmp_seq_rr.sv - combinational round-robin picker for the next enabled channel
//
// Purpose : finds the first set bit of mask at or after ptr, wrapping N_CH-1 -> 0.
// Ports   : mask   [N_CH]  in  - channel enable mask
//           ptr    [IDX_W] in  - search start position
//           onehot [N_CH]  out - selected channel, one-hot (0 when nothing enabled)
//           idx    [IDX_W] out - selected channel index
//           found          out - at least one channel enabled
module tmp_seq_rr
  import tmp_seq_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int IDX_W = idx_w(N_CH)
) (
  input  logic [N_CH-1:0]  mask,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_CH-1:0]  onehot,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  int c;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    c      = 0;
    for (int k = 0; k < N_CH; k++) begin
      c = (int'(ptr) + k) % N_CH;
      if (!found && mask[c[IDX_W-1:0]]) begin
        found                 = 1'b1;
        onehot[c[IDX_W-1:0]]  = 1'b1;
        idx                   = c[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/tmp_seq_ctrl.sv
// rtl/tmp_seq_ctrl.sv - multi-channel diode temperature front-end sequencer
//
// Purpose : steps each enabled channel through PRECHARGE, SMALL, BIG and OUTPUT with
//           BLANK non-overlap gaps between phases; counts comparator ones during BIG
//           and hands the count out over res_if.
// Ports   : clk, reset_n (async, active-low)
//           start          in  - level request; held high = continuous conversions
//           ch_en  [N_CH]  in  - channel enable mask, sampled at PRECHARGE entry
//           cmp            in  - comparator decision, sampled every BIG cycle
//           pi1/pi2, pii1/pii2, pa..pd   out - switch matrix controls
//           src_n, snk     out - balancing current toggles
//           pre_chrg       out - precharge enable
//           setup_bias     out - bias setup enable
//           ch_sel [N_CH]  out - one-hot active channel
//           res_if         master - result / result_ch / valid / ready
// Option  : TMP_SEQ_SETUP_BIAS_EN - enables setup_bias for the first conversion after reset;
//           otherwise setup_bias is tied low and SETUP_CYC has no effect.
module tmp_seq_ctrl
  import tmp_seq_pkg::*;
#(
  parameter int N_CH       = DEF_N_CH,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int PRECHG_CYC = DEF_PRECHG_CYC,
  parameter int BLANK_CYC  = DEF_BLANK_CYC,
  parameter int DIODE_CYC  = DEF_DIODE_CYC,
  parameter int CONV_CYC   = DEF_CONV_CYC,
  parameter int SETUP_CYC  = DEF_SETUP_CYC
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [N_CH-1:0] ch_en,
  input  logic            cmp,
  output logic            pi1,
  output logic            pi2,
  output logic            pii1,
  output logic            pii2,
  output logic            pa,
  output logic            pb,
  output logic            pc,
  output logic            pd,
  output logic            src_n,
  output logic            snk,
  output logic            pre_chrg,
  output logic            setup_bias,
  output logic [N_CH-1:0] ch_sel,
  tmp_seq_ctrl_if.master  res_if
);

  localparam int IDX_W = idx_w(N_CH);

  if (N_CH < 1)                   begin : g_err_nch  $error("N_CH must be at least 1");            end
  if (CONV_CYC > 2**CNT_W - 1)    begin : g_err_conv $error("CONV_CYC does not fit in CNT_W bits"); end
  if (PRECHG_CYC < 1 || BLANK_CYC < 1 || DIODE_CYC < 1 || CONV_CYC < 1)
                                  begin : g_err_cyc  $error("phase lengths must be at least 1");    end
  if (SETUP_CYC < 0)              begin : g_err_set  $error("SETUP_CYC must not be negative");      end

  state_e           state_q, state_d;
  state_e           ret_q, ret_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] ch_idx_q, ch_idx_d;
  logic [N_CH-1:0]  ch_sel_q, ch_sel_d;
  logic [CNT_W-1:0] result_q, result_d;
  logic [IDX_W-1:0] result_ch_q, result_ch_d;
  logic             valid_q, valid_d;
  logic             start_q, start_d;
  sw_t              sw_q, sw_d;
  logic             src_n_q, src_n_d;
  logic             snk_q, snk_d;

  logic             hs;
  logic             go_pre;
  logic             phase_done;
  logic [IDX_W-1:0] ptr_adv;
  logic [IDX_W-1:0] rr_ptr;
  logic [N_CH-1:0]  rr_onehot;
  logic [IDX_W-1:0] rr_idx;
  logic             rr_found;

  // Cycles remaining after the first, loaded on entry to a timed phase.
  function automatic logic [31:0] phase_len(input state_e s);
    case (s)
      ST_PRECHARGE: return 32'(PRECHG_CYC - 1);
      ST_BLANK:     return 32'(BLANK_CYC - 1);
      ST_SMALL:     return 32'(DIODE_CYC - 1);
      ST_BIG:       return 32'(CONV_CYC - 1);
      default:      return 32'd0;
    endcase
  endfunction

  assign hs      = valid_q & res_if.ready;
  assign ptr_adv = (ch_idx_q == IDX_W'(N_CH - 1)) ? '0 : ch_idx_q + IDX_W'(1);
  // On a handshake the pointer moves past the current channel in the same cycle
  // that the next channel is picked, so the picker must see the advanced value.
  assign rr_ptr  = hs ? ptr_adv : ptr_q;

  tmp_seq_rr #(
    .N_CH  (N_CH),
    .IDX_W (IDX_W)
  ) u_rr (
    .mask   (ch_en),
    .ptr    (rr_ptr),
    .onehot (rr_onehot),
    .idx    (rr_idx),
    .found  (rr_found)
  );

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    ptr_d       = ptr_q;
    ch_idx_d    = ch_idx_q;
    ch_sel_d    = ch_sel_q;
    result_d    = result_q;
    result_ch_d = result_ch_q;
    valid_d     = valid_q;
    start_d     = start;
    go_pre      = 1'b0;
    phase_done  = (cnt_q == 32'd0);

    case (state_q)
      // start is taken from its register so PRECHARGE begins one edge after it is seen.
      ST_IDLE: begin
        if (start_q && rr_found) go_pre = 1'b1;
      end
      ST_PRECHARGE: begin
        if (phase_done) begin
          state_d = ST_BLANK;
          ret_d   = ST_SMALL;
          cnt_d   = phase_len(ST_BLANK);
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      ST_BLANK: begin
        if (phase_done) begin
          state_d = ret_q;
          cnt_d   = phase_len(ret_q);
          if (ret_q == ST_OUTPUT) begin
            valid_d     = 1'b1;
            result_d    = acc_q;
            result_ch_d = ch_idx_q;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      ST_SMALL: begin
        if (phase_done) begin
          state_d = ST_BLANK;
          ret_d   = ST_BIG;
          cnt_d   = phase_len(ST_BLANK);
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      ST_BIG: begin
        if (cmp && (acc_q != {CNT_W{1'b1}})) acc_d = acc_q + CNT_W'(1);
        if (phase_done) begin
          state_d = ST_BLANK;
          ret_d   = ST_OUTPUT;
          cnt_d   = phase_len(ST_BLANK);
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      ST_OUTPUT: begin
        if (hs) begin
          valid_d = 1'b0;
          ptr_d   = ptr_adv;
          if (start && rr_found) begin
            go_pre = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            ch_sel_d = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (go_pre) begin
      state_d  = ST_PRECHARGE;
      cnt_d    = phase_len(ST_PRECHARGE);
      ch_sel_d = rr_onehot;
      ch_idx_d = rr_idx;
      acc_d    = '0;
    end

    // Switch outputs follow the state being entered so they register together with it.
    sw_d = '0;
    case (state_d)
      ST_PRECHARGE: begin
        sw_d.pre_chrg = 1'b1;
        sw_d.pb       = 1'b1;
        sw_d.pc       = 1'b1;
        sw_d.pd       = 1'b1;
      end
      ST_SMALL: begin
        sw_d.pii1 = 1'b1;
        sw_d.pii2 = 1'b1;
      end
      ST_BIG: begin
        sw_d.pi1 = 1'b1;
        sw_d.pi2 = 1'b1;
      end
      ST_OUTPUT: begin
        sw_d.pb = 1'b1;
        sw_d.pc = 1'b1;
        sw_d.pd = 1'b1;
      end
      default: sw_d = '0;
    endcase

    // The toggle from the final BIG sample is dropped: the following BLANK forces both low.
    src_n_d = 1'b0;
    snk_d   = 1'b0;
    if (state_q == ST_BIG && state_d == ST_BIG) begin
      src_n_d = src_n_q ^ cmp;
      snk_d   = snk_q ^ ~cmp;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ret_q       <= ST_SMALL;
      cnt_q       <= '0;
      acc_q       <= '0;
      ptr_q       <= '0;
      ch_idx_q    <= '0;
      ch_sel_q    <= '0;
      result_q    <= '0;
      result_ch_q <= '0;
      valid_q     <= 1'b0;
      start_q     <= 1'b0;
      sw_q        <= '0;
      src_n_q     <= 1'b0;
      snk_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ptr_q       <= ptr_d;
      ch_idx_q    <= ch_idx_d;
      ch_sel_q    <= ch_sel_d;
      result_q    <= result_d;
      result_ch_q <= result_ch_d;
      valid_q     <= valid_d;
      start_q     <= start_d;
      sw_q        <= sw_d;
      src_n_q     <= src_n_d;
      snk_q       <= snk_d;
    end
  end

`ifdef TMP_SEQ_SETUP_BIAS_EN
  logic        armed_q, armed_d;
  logic        setup_bias_q, setup_bias_d;
  logic [31:0] big_idx;

  // armed covers only the first conversion after reset; it drops when that conversion leaves BIG.
  always_comb begin
    big_idx = 32'(CONV_CYC - 1) - cnt_d;
    armed_d = armed_q;
    if (state_q == ST_BIG && state_d != ST_BIG) armed_d = 1'b0;
    setup_bias_d = 1'b0;
    if (armed_q) begin
      case (state_d)
        ST_PRECHARGE, ST_SMALL: setup_bias_d = 1'b1;
        ST_BLANK:               setup_bias_d = (state_q != ST_BIG);
        ST_BIG:                 setup_bias_d = (big_idx < 32'(SETUP_CYC));
        default:                setup_bias_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed_q      <= 1'b1;
      setup_bias_q <= 1'b0;
    end else begin
      armed_q      <= armed_d;
      setup_bias_q <= setup_bias_d;
    end
  end

  assign setup_bias = setup_bias_q;
`else
  assign setup_bias = 1'b0;
`endif

  assign pi1      = sw_q.pi1;
  assign pi2      = sw_q.pi2;
  assign pii1     = sw_q.pii1;
  assign pii2     = sw_q.pii2;
  assign pa       = sw_q.pa;
  assign pb       = sw_q.pb;
  assign pc       = sw_q.pc;
  assign pd       = sw_q.pd;
  assign pre_chrg = sw_q.pre_chrg;
  assign src_n    = src_n_q;
  assign snk      = snk_q;
  assign ch_sel   = ch_sel_q;

  assign res_if.result    = result_q;
  assign res_if.result_ch = result_ch_q;
  assign res_if.valid     = valid_q;

endmodule

// File: tb/tb_tmp_seq_ctrl.sv
// tb/tb_tmp_seq_ctrl.sv - scoreboard bench for tmp_seq_ctrl with default parameters
module tb_tmp_seq_ctrl;
  import tmp_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic       cmp = 1'b0;
  logic [3:0] ch_en = 4'b0000;
  logic       pi1, pi2, pii1, pii2, pa, pb, pc, pd, src_n, snk, pre_chrg, setup_bias;
  logic [3:0] ch_sel;
  logic [26:0] all_outs;

  tmp_seq_ctrl_if #(.N_CH(4), .CNT_W(8)) rif ();

  tmp_seq_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .ch_en      (ch_en),
    .cmp        (cmp),
    .pi1        (pi1),
    .pi2        (pi2),
    .pii1       (pii1),
    .pii2       (pii2),
    .pa         (pa),
    .pb         (pb),
    .pc         (pc),
    .pd         (pd),
    .src_n      (src_n),
    .snk        (snk),
    .pre_chrg   (pre_chrg),
    .setup_bias (setup_bias),
    .ch_sel     (ch_sel),
    .res_if     (rif)
  );

`ifdef TMP_SEQ_SETUP_BIAS_EN
  localparam int EXP_SB = 21;
`else
  localparam int EXP_SB = 0;
`endif

  int          checks = 0;
  int          failures = 0;
  logic [9:0]  exp_q[$];
  logic [9:0]  mon_e;

  assign all_outs = {pi1, pi2, pii1, pii2, pa, pb, pc, pd, src_n, snk, pre_chrg, setup_bias,
                     ch_sel, rif.result, rif.result_ch, rif.valid};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Monitor: every accepted result is popped against the expectation queue.
  always @(negedge clk) begin
    if (reset_n && rif.valid && rif.ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got result=%0d ch=%0d expected none", rif.result, rif.result_ch);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_result", 32'(rif.result), 32'(mon_e[9:2]));
        check("sb_ch", 32'(rif.result_ch), 32'(mon_e[1:0]));
      end
    end
  end

  initial begin : main
    int first_v, n_snk, n_src, n_pi, n_pii, n_pre, n_sb, nval, npre, bad;
    logic prev_snk, prev_src, prev_pre;
    logic [3:0] seq [3];

    rif.ready = 1'b1;
    #1 reset_n = 1'b0;
    #1 check("reset_outs", 32'(all_outs), 32'd0);
    do_reset();

    // T1: single channel, cmp always 1, start dropped once the result shows
    ch_en = 4'b0001; cmp = 1'b1; start = 1'b1;
    exp_q.push_back({8'd128, 2'd0});
    first_v = -1; n_snk = 0; n_pi = 0; n_pii = 0; n_pre = 0; n_sb = 0; prev_snk = 1'b0;
    for (int k = 0; k < 160; k++) begin
      step();
      if (k == 0)  check("idle_after_edge0", 32'(pre_chrg), 32'd0);
      if (k == 1)  check("pre_outs", 32'({pre_chrg, pa, pb, pc, pd, ch_sel}), 32'(9'b101110001));
      if (k == 12) check("blank_outs", 32'({pi1, pi2, pii1, pii2, pa, pb, pc, pd, pre_chrg, src_n, snk}), 32'd0);
      if (snk != prev_snk) n_snk++;
      prev_snk = snk;
      n_pi  += int'(pi1);
      n_pii += int'(pii1);
      n_pre += int'(pre_chrg);
      n_sb  += int'(setup_bias);
      if (rif.valid && first_v < 0) begin
        first_v = k;
        start = 1'b0;
      end
    end
    check("valid_edge", 32'(first_v), 32'd145);
    check("snk_toggles_all_ones", 32'(n_snk), 32'd0);
    check("big_cycles", 32'(n_pi), 32'd128);
    check("small_cycles", 32'(n_pii), 32'd2);
    check("precharge_cycles", 32'(n_pre), 32'd11);
    check("setup_bias_conv1", 32'(n_sb), 32'(EXP_SB));
    check("idle_after_stop", 32'({rif.valid, pre_chrg, pb}), 32'd0);

    // T2: alternating cmp, pointer wraps back to channel 0
    start = 1'b1;
    exp_q.push_back({8'd64, 2'd0});
    first_v = -1; n_snk = 0; n_src = 0; n_sb = 0; prev_snk = snk; prev_src = src_n;
    for (int k = 0; k < 160; k++) begin
      step();
      if (snk != prev_snk) n_snk++;
      if (src_n != prev_src) n_src++;
      prev_snk = snk;
      prev_src = src_n;
      n_sb += int'(setup_bias);
      if (k == 144) check("blank_after_big", 32'({src_n, snk, pi1}), 32'd0);
      if (rif.valid && first_v < 0) begin
        first_v = k;
        start = 1'b0;
      end
      cmp = ~cmp;
    end
    check("src_toggles", 32'(n_src), 32'd64);
    check("snk_toggles", 32'(n_snk), 32'd64);
    check("setup_bias_conv2", 32'(n_sb), 32'd0);

    // T3: round robin over channels 1 and 3
    do_reset();
    ch_en = 4'b1010; cmp = 1'b1; start = 1'b1;
    exp_q.push_back({8'd128, 2'd1});
    exp_q.push_back({8'd128, 2'd3});
    exp_q.push_back({8'd128, 2'd1});
    nval = 0; npre = 0; prev_pre = 1'b0;
    for (int k = 0; k < 600 && nval < 3; k++) begin
      step();
      if (pre_chrg && !prev_pre && npre < 3) begin
        seq[npre] = ch_sel;
        npre++;
      end
      prev_pre = pre_chrg;
      if (rif.valid) begin
        nval++;
        if (nval == 3) start = 1'b0;
      end
    end
    repeat (3) step();
    check("rr_results", 32'(nval), 32'd3);
    check("rr_sel0", 32'(seq[0]), 32'(4'b0010));
    check("rr_sel1", 32'(seq[1]), 32'(4'b1000));
    check("rr_sel2", 32'(seq[2]), 32'(4'b0010));

    // T4: backpressure holds OUTPUT for 20 cycles
    do_reset();
    ch_en = 4'b0100; cmp = 1'b1; start = 1'b1; rif.ready = 1'b0;
    exp_q.push_back({8'd128, 2'd2});
    for (int k = 0; k < 200 && !rif.valid; k++) step();
    check("bp_valid_seen", 32'(rif.valid), 32'd1);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (rif.valid !== 1'b1 || rif.result !== 8'd128 || {pb, pc, pd} !== 3'b111 ||
          pre_chrg !== 1'b0 || pa !== 1'b0)
        bad++;
    end
    check("bp_hold", 32'(bad), 32'd0);
    @(posedge clk);
    #1 rif.ready = 1'b1;
    @(negedge clk);
    step();
    check("bp_release_precharge", 32'({pre_chrg, rif.valid}), 32'(2'b10));

    // T5: reset mid-BIG, then start with no channels enabled
    repeat (20) step();
    check("in_big", 32'(pi1), 32'd1);
    #2 reset_n = 1'b0;
    #1 check("reset_mid_big", 32'(all_outs), 32'd0);
    @(negedge clk);
    ch_en = 4'b0000; start = 1'b1; reset_n = 1'b1;
    n_pre = 0; nval = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      n_pre += int'(pre_chrg);
      nval  += int'(rif.valid);
    end
    check("idle_no_channels", 32'(n_pre + nval), 32'd0);
    check("idle_ch_sel", 32'(ch_sel), 32'd0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
